dram_bank_responder: RTL and testbench
======================================

Name: dram_bank_responder

Overview:
- Device-side end of the controller command interface: accepts cmd_req/cmd with one-hot bank/row/col selects, answers with cmd_ack.
- Models per-bank open-row state and a bank/row/col storage array, one DATA_WIDTH word per location.
- Moves data bit-serially on the DRAM data line: it drives the line for reads and samples it for writes.
- Used as the DRAM behavioural model / responder in controller integration; the top level ties dq_out/dq_oe/dq_in onto the inout data line.

Parameters:
- DATA_WIDTH, 8, bits per stored word; also the serial burst length.
- NUM_OF_BANKS, 8, number of banks; width of bank_sel.
- NUM_OF_ROWS, 128, rows per bank; width of row_sel.
- NUM_OF_COLS, 8, columns per row; width of col_sel.
- T_RCD, 3, cycles from ACTIVATE accept to ack (must be >= 1).
- T_RFC, 16, cycles from REFRESH accept to ack (must be >= 1).

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  asynchronous active-low reset.
- cmd_req  in  1  command request level from the controller.
- cmd  in  2  command code: 00 REFRESH, 01 ACTIVATE, 10 READ, 11 WRITE.
- bank_sel  in  NUM_OF_BANKS  one-hot bank select.
- row_sel  in  NUM_OF_ROWS  one-hot row select; used by ACTIVATE, READ and WRITE.
- col_sel  in  NUM_OF_COLS  one-hot column select; used by READ and WRITE.
- dq_in  in  1  serial write data, MSB first.
- dq_out  out  1  serial read data, MSB first.
- dq_oe  out  1  high while dq_out must drive the data line.
- cmd_ack  out  1  four-phase acknowledge.
- cmd_err  out  1  error status for the acknowledged command; valid while cmd_ack=1.

Behaviour:
- Reset (async, rst_b=0):
  - State goes to IDLE.
  - cmd_ack=0, cmd_err=0, dq_oe=0, dq_out=0.
  - All banks closed; open-row registers cleared.
  - Storage array is not reset.
  - Reset mid-command aborts it; a partial WRITE does not modify storage.
- FSM states: IDLE, ACT_WAIT, RD_SHIFT, WR_SHIFT, REF_BUSY, ACK.
- Accept (edge E0):
  - Occurs in IDLE at the first rising edge with cmd_req=1.
  - Captures cmd, the encoded bank/row/col indices, and an error check.
- Error at accept. Any of the following sends the FSM directly to ACK with cmd_err=1 and no side effects:
  - bank_sel not one-hot (REFRESH ignores selects and never errors).
  - row_sel not one-hot, for ACTIVATE, READ or WRITE.
  - col_sel not one-hot, for READ or WRITE.
  - READ/WRITE to a closed bank.
  - READ/WRITE with row index not equal to that bank's open row.
- ACTIVATE:
  - ACT_WAIT counts T_RCD cycles.
  - At the end it records the open row for the bank and enters ACK.
  - Re-activating an already open bank replaces its open row (implicit precharge).
- READ:
  - RD_SHIFT lasts exactly DATA_WIDTH cycles, starting the cycle after E0.
  - dq_oe=1 throughout RD_SHIFT.
  - dq_out carries word bit DATA_WIDTH-1 first, then bit 0 last.
  - The FSM then enters ACK; dq_oe=0 and dq_out=0 outside RD_SHIFT.
- WRITE:
  - WR_SHIFT samples dq_in on DATA_WIDTH consecutive rising edges, starting with the edge one cycle after E0, MSB first.
  - The word is committed to storage on the last sampling edge; the FSM then enters ACK.
- REFRESH:
  - REF_BUSY counts T_RFC cycles.
  - At the end all banks are closed and the FSM enters ACK.
- ACK (four-phase handshake):
  - cmd_ack=1 and cmd_err is held.
  - The FSM stays in ACK while cmd_req=1.
  - The first edge with cmd_req=0 returns it to IDLE, with cmd_ack=0 and cmd_err=0.
  - A new command cannot be accepted until after that edge.
- cmd_req deasserted early (outside IDLE/ACK): ignored; the command completes.
- cmd/selects changing after E0: ignored; only the captured values are used.
- One command is in flight at a time; there is no queuing.
- Counters are $clog2-sized and saturate at their terminal count, not wrap.
- Storage address = {bank_idx, row_idx, col_idx}; depth = NUM_OF_BANKS*NUM_OF_ROWS*NUM_OF_COLS.

Test Plan:
- Reset, then ACTIVATE bank 2 row 5 (bank_sel=8'h04, row_sel bit5) -> cmd_ack rises exactly T_RCD=3 cycles after accept; cmd_err=0; cmd_ack falls one edge after cmd_req drops.
- WRITE bank2 row5 col3, dq_in sequence 1,0,1,0,0,1,0,1 -> ack after 8 cycles, cmd_err=0. Then READ the same location -> dq_oe=1 for 8 cycles, dq_out=1,0,1,0,0,1,0,1 (0xA5), ack following.
- READ bank2 row6 while row5 is open -> cmd_ack on the cycle after accept, cmd_err=1, dq_oe never asserted, storage unchanged.
- bank_sel=8'h06 (two-hot) with ACTIVATE -> immediate ack with cmd_err=1; the bank stays closed, so a later READ to that bank errors.
- REFRESH after opening banks 0 and 2 -> ack after T_RFC=16 cycles; subsequent READ to bank 2 row 5 -> cmd_err=1.
- Assert rst_b=0 at the 4th bit of a WRITE of 0xFF over a location holding 0xA5 -> outputs return to reset values immediately. Re-ACTIVATE, then READ -> 0xA5 (no partial commit).

Source files
------------

// File: rtl/dram_bank_responder.sv
// Behavioural DRAM bank responder: one-hot command interface with four-phase ack,
// per-bank open-row tracking and a bit-serial (MSB first) data line.
module dram_bank_responder #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int T_RCD        = 3,
  parameter int T_RFC        = 16
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    cmd_req,
  input  logic [1:0]              cmd,
  input  logic [NUM_OF_BANKS-1:0] bank_sel,
  input  logic [NUM_OF_ROWS-1:0]  row_sel,
  input  logic [NUM_OF_COLS-1:0]  col_sel,
  input  logic                    dq_in,
  output logic                    dq_out,
  output logic                    dq_oe,
  output logic                    cmd_ack,
  output logic                    cmd_err
);
  localparam int BW      = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1;
  localparam int RW      = (NUM_OF_ROWS > 1) ? $clog2(NUM_OF_ROWS) : 1;
  localparam int CW      = (NUM_OF_COLS > 1) ? $clog2(NUM_OF_COLS) : 1;
  localparam int AW      = BW + RW + CW;
  localparam int DEPTH   = NUM_OF_BANKS * NUM_OF_ROWS * NUM_OF_COLS;
  localparam int CNT_MAX = (T_RFC > T_RCD) ? ((T_RFC > DATA_WIDTH) ? T_RFC : DATA_WIDTH)
                                           : ((T_RCD > DATA_WIDTH) ? T_RCD : DATA_WIDTH);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] RCD_LAST = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] RFC_LAST = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] DW_LAST  = CNT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] CMD_REF = 2'b00;
  localparam logic [1:0] CMD_ACT = 2'b01;
  localparam logic [1:0] CMD_RD  = 2'b10;
  localparam logic [1:0] CMD_WR  = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACT_WAIT = 3'd1,
    RD_SHIFT = 3'd2,
    WR_SHIFT = 3'd3,
    REF_BUSY = 3'd4,
    ACK      = 3'd5
  } state_e;

  state_e state_r, state_n;
  logic [CNT_W-1:0]                   cnt_r, cnt_n;
  logic [DATA_WIDTH-1:0]              rd_sh_r, rd_sh_n, wr_sh_r, wr_sh_n, rd_word_s;
  logic                               ack_n, err_n, oe_n, out_n;
  logic                               capture_s, act_done_s, ref_done_s, we_s, acc_err_s, hit_s;
  logic [BW-1:0]                      bank_idx_s, bank_idx_r;
  logic [RW-1:0]                      row_idx_s, row_idx_r;
  logic [CW-1:0]                      col_idx_s, col_idx_r;
  logic [NUM_OF_BANKS-1:0]            open_r;
  logic [NUM_OF_BANKS-1:0][RW-1:0]    open_row_r;
  logic [DATA_WIDTH-1:0]              mem_r [DEPTH];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_TOP) ? v : v + CNT_W'(1);
  endfunction

  // One-hot select encoders; the index is only trusted when the select is one-hot.
  always_comb begin
    bank_idx_s = '0;
    row_idx_s  = '0;
    col_idx_s  = '0;
    for (int i = 0; i < NUM_OF_BANKS; i++) bank_idx_s = bank_sel[i] ? BW'(i) : bank_idx_s;
    for (int i = 0; i < NUM_OF_ROWS; i++)  row_idx_s  = row_sel[i]  ? RW'(i) : row_idx_s;
    for (int i = 0; i < NUM_OF_COLS; i++)  col_idx_s  = col_sel[i]  ? CW'(i) : col_idx_s;
  end

  assign hit_s     = open_r[bank_idx_s] && (open_row_r[bank_idx_s] == row_idx_s);
  assign rd_word_s = mem_r[{bank_idx_s, row_idx_s, col_idx_s}];

  // Accept-time error check
  always_comb begin
    case (cmd)
      CMD_REF: acc_err_s = 1'b0;
      CMD_ACT: acc_err_s = !($onehot(bank_sel) && $onehot(row_sel));
      default: acc_err_s = !($onehot(bank_sel) && $onehot(row_sel) && $onehot(col_sel) && hit_s);
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    ack_n      = cmd_ack;
    err_n      = cmd_err;
    oe_n       = dq_oe;
    out_n      = dq_out;
    rd_sh_n    = rd_sh_r;
    wr_sh_n    = wr_sh_r;
    capture_s  = 1'b0;
    act_done_s = 1'b0;
    ref_done_s = 1'b0;
    we_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_req) begin
          capture_s = 1'b1;
          cnt_n     = '0;
          if (acc_err_s) begin
            state_n = ACK;
            ack_n   = 1'b1;
            err_n   = 1'b1;
          end else begin
            case (cmd)
              CMD_REF: state_n = REF_BUSY;
              CMD_ACT: state_n = ACT_WAIT;
              CMD_RD: begin
                // First bit goes out on the accept edge so the burst spans exactly DATA_WIDTH cycles
                state_n = RD_SHIFT;
                oe_n    = 1'b1;
                out_n   = rd_word_s[DATA_WIDTH-1];
                rd_sh_n = {rd_word_s[DATA_WIDTH-2:0], 1'b0};
              end
              CMD_WR:  state_n = WR_SHIFT;
              default: state_n = IDLE;
            endcase
          end
        end else begin
          state_n = IDLE;
        end
      end
      ACT_WAIT: begin
        if (cnt_r == RCD_LAST) begin
          act_done_s = 1'b1;
          state_n    = ACK;
          ack_n      = 1'b1;
        end else begin
          cnt_n = sat_inc(cnt_r);
        end
      end
      REF_BUSY: begin
        if (cnt_r == RFC_LAST) begin
          ref_done_s = 1'b1;
          state_n    = ACK;
          ack_n      = 1'b1;
        end else begin
          cnt_n = sat_inc(cnt_r);
        end
      end
      RD_SHIFT: begin
        if (cnt_r == DW_LAST) begin
          state_n = ACK;
          ack_n   = 1'b1;
          oe_n    = 1'b0;
          out_n   = 1'b0;
        end else begin
          out_n   = rd_sh_r[DATA_WIDTH-1];
          rd_sh_n = {rd_sh_r[DATA_WIDTH-2:0], 1'b0};
          cnt_n   = sat_inc(cnt_r);
        end
      end
      WR_SHIFT: begin
        wr_sh_n = {wr_sh_r[DATA_WIDTH-2:0], dq_in};
        if (cnt_r == DW_LAST) begin
          we_s    = 1'b1;
          state_n = ACK;
          ack_n   = 1'b1;
        end else begin
          cnt_n = sat_inc(cnt_r);
        end
      end
      ACK: begin
        if (!cmd_req) begin
          state_n = IDLE;
          ack_n   = 1'b0;
          err_n   = 1'b0;
        end else begin
          state_n = ACK;
        end
      end
      default: begin
        state_n = IDLE;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        oe_n    = 1'b0;
        out_n   = 1'b0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_r <= IDLE;
    else        state_r <= state_n;
  end

  // Datapath, captured indices, open-row table and registered outputs
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_r      <= '0;
      rd_sh_r    <= '0;
      wr_sh_r    <= '0;
      cmd_ack    <= 1'b0;
      cmd_err    <= 1'b0;
      dq_oe      <= 1'b0;
      dq_out     <= 1'b0;
      bank_idx_r <= '0;
      row_idx_r  <= '0;
      col_idx_r  <= '0;
      open_r     <= '0;
      open_row_r <= '0;
    end else begin
      cnt_r   <= cnt_n;
      rd_sh_r <= rd_sh_n;
      wr_sh_r <= wr_sh_n;
      cmd_ack <= ack_n;
      cmd_err <= err_n;
      dq_oe   <= oe_n;
      dq_out  <= out_n;
      if (capture_s) begin
        bank_idx_r <= bank_idx_s;
        row_idx_r  <= row_idx_s;
        col_idx_r  <= col_idx_s;
      end
      if (ref_done_s) begin
        open_r     <= '0;
        open_row_r <= '0;
      end else if (act_done_s) begin
        open_r[bank_idx_r]     <= 1'b1;
        open_row_r[bank_idx_r] <= row_idx_r;
      end
    end
  end

  // Storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (we_s) mem_r[AW'({bank_idx_r, row_idx_r, col_idx_r})] <= wr_sh_n;
  end
endmodule

// File: tb/tb_dram_bank_responder.sv
// Self-checking bench for dram_bank_responder: directed table, reset corner cases,
// then randomized commands checked against a bank/row/storage model.
module tb_dram_bank_responder;
  logic         clk = 1'b0;
  logic         rst_b, cmd_req, dq_in;
  logic [1:0]   cmd;
  logic [7:0]   bank_sel, col_sel;
  logic [127:0] row_sel;
  logic         dq_out, dq_oe, cmd_ack, cmd_err;

  int n_vec = 0;
  int n_bad = 0;

  bit         m_open [8];
  int         m_row  [8];
  logic [7:0] m_mem  [int];

  typedef struct {
    logic [1:0]   c;
    logic [7:0]   b;
    logic [127:0] r;
    logic [7:0]   col;
    logic [7:0]   wd;
    logic         err;
    int           lat;
    bit           rd_chk;
    logic [7:0]   rd;
    string        nm;
  } vec_t;
  vec_t tbl [$];

  dram_bank_responder dut (
    .clk(clk), .rst_b(rst_b), .cmd_req(cmd_req), .cmd(cmd),
    .bank_sel(bank_sel), .row_sel(row_sel), .col_sel(col_sel),
    .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe),
    .cmd_ack(cmd_ack), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [127:0] v);
    for (int i = 0; i < 128; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_open[i] = 1'b0;
      m_row[i]  = 0;
    end
  endtask

  // Reference model: decides error, ack latency and read data, then updates bank/storage state.
  task automatic model_step(input logic [1:0] c, input logic [7:0] b, input logic [127:0] r,
                            input logic [7:0] col, input logic [7:0] wd,
                            output logic e, output int lat, output bit has_rd, output logic [7:0] rd);
    bit bok, rok, cok;
    int bi, ri, ci, key;
    bok = ($countones(b) == 1);
    rok = ($countones(r) == 1);
    cok = ($countones(col) == 1);
    bi  = idx_of({120'd0, b});
    ri  = idx_of(r);
    ci  = idx_of({120'd0, col});
    e = 1'b0; lat = 0; has_rd = 1'b0; rd = 8'h00;
    case (c)
      2'b00: begin
        lat = 16;
        model_reset();
      end
      2'b01: begin
        if (!(bok && rok)) e = 1'b1;
        else begin
          lat = 3;
          m_open[bi] = 1'b1;
          m_row[bi]  = ri;
        end
      end
      default: begin
        if (!(bok && rok && cok) || !m_open[bi] || m_row[bi] != ri) e = 1'b1;
        else begin
          lat = 8;
          key = bi * 1024 + ri * 8 + ci;
          if (c == 2'b11) m_mem[key] = wd;
          else if (m_mem.exists(key)) begin
            has_rd = 1'b1;
            rd = m_mem[key];
          end
        end
      end
    endcase
  endtask

  // Issue one command, follow it to ack, check burst/latency/err, then release the handshake.
  task automatic run_cmd(input logic [1:0] c, input logic [7:0] b, input logic [127:0] r,
                         input logic [7:0] col, input logic [7:0] wd, input bit early,
                         input logic e_err, input int e_lat, input bit e_chk, input logic [7:0] e_rd,
                         input string nm);
    int n = 0;
    int oe_cnt = 0;
    logic [7:0] got = 8'h00;
    bit is_rd;
    is_rd = (c == 2'b10) && !e_err;
    @(negedge clk);
    cmd_req = 1'b1; cmd = c; bank_sel = b; row_sel = r; col_sel = col; dq_in = 1'b0;
    @(posedge clk); @(negedge clk);
    while (!cmd_ack && n < 40) begin
      if (dq_oe) begin
        got = {got[6:0], dq_out};
        oe_cnt++;
      end
      if (n < 8) dq_in = wd[7-n];
      cmd = 2'($urandom); bank_sel = 8'($urandom); row_sel = {4{$urandom}}; col_sel = 8'($urandom);
      if (early) cmd_req = 1'b0;
      @(posedge clk); @(negedge clk);
      n++;
    end
    chk({nm, " ack latency"}, 64'(n), 64'(e_lat));
    chk({nm, " cmd_err"}, 64'(cmd_err), 64'(e_err));
    chk({nm, " dq_oe cycles"}, 64'(oe_cnt), is_rd ? 64'd8 : 64'd0);
    chk({nm, " dq idle at ack"}, {62'd0, dq_oe, dq_out}, 64'd0);
    if (e_chk) chk({nm, " read data"}, 64'(got), 64'(e_rd));
    if (!early) begin
      @(posedge clk); @(negedge clk);
      chk({nm, " ack held"}, {62'd0, cmd_ack, cmd_err}, {62'd0, 1'b1, e_err});
    end
    cmd_req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({nm, " ack release"}, {62'd0, cmd_ack, cmd_err}, 64'd0);
  endtask

  task automatic add(input logic [1:0] c, input logic [7:0] b, input logic [127:0] r, input logic [7:0] col,
                     input logic [7:0] wd, input logic err, input int lat, input bit rd_chk,
                     input logic [7:0] rd, input string nm);
    vec_t v;
    v.c = c; v.b = b; v.r = r; v.col = col; v.wd = wd;
    v.err = err; v.lat = lat; v.rd_chk = rd_chk; v.rd = rd; v.nm = nm;
    tbl.push_back(v);
  endtask

  initial begin
    logic e;
    int lat;
    bit hr;
    logic [7:0] rd;
    logic [1:0] c;
    logic [7:0] b, col, wd;
    logic [127:0] r;
    int ri;

    rst_b = 1'b0; cmd_req = 1'b0; cmd = 2'b00; bank_sel = 8'h00;
    row_sel = 128'd0; col_sel = 8'h00; dq_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset cmd_ack", 64'(cmd_ack), 64'd0);
    chk("reset cmd_err", 64'(cmd_err), 64'd0);
    chk("reset dq_oe",   64'(dq_oe),   64'd0);
    chk("reset dq_out",  64'(dq_out),  64'd0);
    rst_b = 1'b1;

    add(2'b01, 8'h04, 128'd1 << 5,   8'h01, 8'h00, 1'b0, 3,  1'b0, 8'h00, "act b2 r5");
    add(2'b11, 8'h04, 128'd1 << 5,   8'h08, 8'hA5, 1'b0, 8,  1'b0, 8'h00, "wr b2 r5 c3");
    add(2'b10, 8'h04, 128'd1 << 5,   8'h08, 8'h00, 1'b0, 8,  1'b1, 8'hA5, "rd b2 r5 c3");
    add(2'b10, 8'h04, 128'd1 << 6,   8'h08, 8'h00, 1'b1, 0,  1'b0, 8'h00, "rd wrong row");
    add(2'b10, 8'h04, 128'd1 << 5,   8'h08, 8'h00, 1'b0, 8,  1'b1, 8'hA5, "rd after miss");
    add(2'b01, 8'h06, 128'd1 << 1,   8'h01, 8'h00, 1'b1, 0,  1'b0, 8'h00, "act two-hot bank");
    add(2'b10, 8'h02, 128'd1 << 1,   8'h02, 8'h00, 1'b1, 0,  1'b0, 8'h00, "rd closed b1");
    add(2'b01, 8'h01, 128'd1 << 127, 8'h01, 8'h00, 1'b0, 3,  1'b0, 8'h00, "act b0 r127");
    add(2'b11, 8'h01, 128'd1 << 127, 8'h80, 8'h3C, 1'b0, 8,  1'b0, 8'h00, "wr b0 r127 c7");
    add(2'b10, 8'h01, 128'd1 << 127, 8'h80, 8'h00, 1'b0, 8,  1'b1, 8'h3C, "rd b0 r127 c7");
    add(2'b01, 8'h04, 128'd0,        8'h01, 8'h00, 1'b1, 0,  1'b0, 8'h00, "act zero row");
    add(2'b10, 8'h04, 128'd1 << 5,   8'h0C, 8'h00, 1'b1, 0,  1'b0, 8'h00, "rd two-hot col");
    add(2'b10, 8'h04, 128'd1 << 5,   8'h08, 8'h00, 1'b0, 8,  1'b1, 8'hA5, "rd row kept");
    add(2'b00, 8'h00, 128'd0,        8'h00, 8'h00, 1'b0, 16, 1'b0, 8'h00, "refresh");
    add(2'b10, 8'h04, 128'd1 << 5,   8'h08, 8'h00, 1'b1, 0,  1'b0, 8'h00, "rd after refresh");
    add(2'b11, 8'h01, 128'd1 << 127, 8'h80, 8'h55, 1'b1, 0,  1'b0, 8'h00, "wr after refresh");

    foreach (tbl[i]) begin
      model_step(tbl[i].c, tbl[i].b, tbl[i].r, tbl[i].col, tbl[i].wd, e, lat, hr, rd);
      run_cmd(tbl[i].c, tbl[i].b, tbl[i].r, tbl[i].col, tbl[i].wd, 1'b0,
              tbl[i].err, tbl[i].lat, tbl[i].rd_chk, tbl[i].rd, tbl[i].nm);
    end

    // Reset at the 4th bit of a WRITE of 0xFF over 0xA5 must not commit anything.
    model_step(2'b01, 8'h04, 128'd1 << 5, 8'h01, 8'h00, e, lat, hr, rd);
    run_cmd(2'b01, 8'h04, 128'd1 << 5, 8'h01, 8'h00, 1'b0, 1'b0, 3, 1'b0, 8'h00, "reopen b2 r5");
    @(negedge clk);
    cmd_req = 1'b1; cmd = 2'b11; bank_sel = 8'h04; row_sel = 128'd1 << 5; col_sel = 8'h08;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      dq_in = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    chk("mid-write no ack", 64'(cmd_ack), 64'd0);
    dq_in = 1'b1;
    rst_b = 1'b0;
    #1;
    chk("mid-write reset outputs", {60'd0, cmd_ack, cmd_err, dq_oe, dq_out}, 64'd0);
    cmd_req = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    model_reset();
    model_step(2'b01, 8'h04, 128'd1 << 5, 8'h01, 8'h00, e, lat, hr, rd);
    run_cmd(2'b01, 8'h04, 128'd1 << 5, 8'h01, 8'h00, 1'b0, 1'b0, 3, 1'b0, 8'h00, "act after reset");
    run_cmd(2'b10, 8'h04, 128'd1 << 5, 8'h08, 8'h00, 1'b0, 1'b0, 8, 1'b1, 8'hA5, "rd no partial commit");

    // Reset in the middle of a READ burst drops dq_oe/dq_out immediately.
    @(negedge clk);
    cmd_req = 1'b1; cmd = 2'b10; bank_sel = 8'h04; row_sel = 128'd1 << 5; col_sel = 8'h08;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid-read dq_oe", 64'(dq_oe), 64'd1);
    rst_b = 1'b0;
    #1;
    chk("mid-read reset outputs", {60'd0, cmd_ack, cmd_err, dq_oe, dq_out}, 64'd0);
    cmd_req = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    model_reset();

    // Randomized traffic over a small bank/row/col window so hits and misses both occur.
    for (int i = 0; i < 120; i++) begin
      c = 2'($urandom_range(0, 3));
      if (c == 2'b00 && $urandom_range(0, 3) != 0) c = 2'b01;
      b = 8'h01 << $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) b = 8'($urandom);
      ri = $urandom_range(0, 3);
      if (ri == 3) ri = 127;
      r = 128'd0;
      r[ri] = 1'b1;
      if ($urandom_range(0, 11) == 0) r = (ri == 127) ? 128'd0 : r | (128'd1 << (ri + 1));
      col = 8'h01 << $urandom_range(0, 3);
      if ($urandom_range(0, 11) == 0) col = 8'($urandom);
      wd = 8'($urandom);
      model_step(c, b, r, col, wd, e, lat, hr, rd);
      run_cmd(c, b, r, col, wd, ($urandom_range(0, 4) == 0), e, lat, hr, rd, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
